// File: rtl/agc_pkg.sv
// Shared types and helpers for the AGC successive-approximation gain tracker.
package agc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_DECIDE,
    ST_LOCKED
  } agc_state_e;

  localparam int DEF_SIG_W       = 16;
  localparam int DEF_HIGH_THRESH = (1 << (DEF_SIG_W - 1)) - 1;
  localparam int DEF_LOW_THRESH  = 1 << (DEF_SIG_W - 3);

  // |x| for a w-bit signed value; the most negative code folds onto the positive max.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] a;
    int                 mx;
    mx = (1 << (w - 1)) - 1;
    a  = (x < 0) ? -x : x;
    if (a > mx) a = mx;
    return a;
  endfunction

endpackage

// File: rtl/agc_window_detector.sv
// Peak-magnitude and overload accumulation over DWELL valid samples.
module agc_window_detector
  import agc_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int DWELL = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [SIG_W-1:0] sample_i,
  input  logic             valid_i,
  input  logic             ovf_i,
  output logic [SIG_W-1:0] peak_o,
  output logic             ovf_o,
  output logic             done_o
);

  localparam int              CW   = $clog2(DWELL + 1);
  localparam logic [CW-1:0]   LAST = CW'(DWELL - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SIG_W-1:0] peak_q, peak_d;
  logic             ovf_q, ovf_d;
  logic [SIG_W-1:0] mag;

  assign mag    = SIG_W'(abs_sat(32'(signed'(sample_i)), SIG_W));
  // Combinational so the FSM leaves MEASURE on the edge that takes the last sample.
  assign done_o = en_i & valid_i & (cnt_q == LAST);

  always_comb begin
    peak_d = peak_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      peak_d = '0;
      ovf_d  = 1'b0;
      cnt_d  = '0;
    end else if (en_i && valid_i) begin
      if (mag > peak_q) peak_d = mag;
      ovf_d = ovf_q | ovf_i;
      cnt_d = done_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      peak_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      peak_q <= peak_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  assign peak_o = peak_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/agc_sar_tracker.sv
// SAR gain-code search driven by ADC overload and peak magnitude.
// Define AGC_TRACK_EN to keep nudging the gain by +-1 after lock.
module agc_sar_tracker
  import agc_pkg::*;
#(
  parameter int SIG_W       = DEF_SIG_W,
  parameter int GAIN_W      = 6,
  parameter int DWELL       = 16,
  parameter int SETTLE_CYC  = 4,
  parameter int HIGH_THRESH = (1 << (SIG_W - 1)) - 1,
  parameter int LOW_THRESH  = 1 << (SIG_W - 3)
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              start,
  input  logic              freeze,
  input  logic [SIG_W-1:0]  sample,
  input  logic              sample_valid,
  input  logic              overload,
  output logic [GAIN_W-1:0] gain,
  output logic              busy,
  output logic              locked
);

  localparam int                KW     = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;
  localparam int                SW     = $clog2(SETTLE_CYC + 1);
  localparam logic [SW-1:0]     S_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [GAIN_W-1:0] MID    = GAIN_W'(1) << (GAIN_W - 1);
  localparam logic [GAIN_W-1:0] GMAX   = '1;
  localparam logic [SIG_W-1:0]  HI_T   = SIG_W'(HIGH_THRESH);
  localparam logic [SIG_W-1:0]  LO_T   = SIG_W'(LOW_THRESH);

  agc_state_e        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d, g_try;
  logic [KW-1:0]     k_q, k_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic              busy_q, busy_d, locked_q, locked_d;
  logic              win_clr, win_en, win_done, win_ovf;
  logic [SIG_W-1:0]  win_peak;
  logic              too_loud;

  agc_window_detector #(
    .SIG_W (SIG_W),
    .DWELL (DWELL)
  ) u_win (
    .clk_i    (clk),
    .rst_i    (RESET),
    .clear_i  (win_clr),
    .en_i     (win_en),
    .sample_i (sample),
    .valid_i  (sample_valid),
    .ovf_i    (overload),
    .peak_o   (win_peak),
    .ovf_o    (win_ovf),
    .done_o   (win_done)
  );

  assign too_loud = win_ovf | (win_peak >= HI_T);

`ifndef AGC_TRACK_EN
  // Quiet threshold only matters to tracking; keep it referenced when compiled out.
  logic unused_low;
  assign unused_low = ^LO_T;
`endif

  always_comb begin
    state_d  = state_q;
    gain_d   = gain_q;
    k_d      = k_q;
    scnt_d   = scnt_q;
    busy_d   = busy_q;
    locked_d = locked_q;
    win_clr  = 1'b0;
    win_en   = 1'b0;
    g_try    = gain_q;
    if (start) begin
      gain_d   = MID;
      k_d      = KW'(GAIN_W - 1);
      scnt_d   = '0;
      busy_d   = 1'b1;
      locked_d = 1'b0;
      win_clr  = 1'b1;
      state_d  = ST_SETTLE;
    end else if (!freeze) begin
      unique case (state_q)
        ST_SETTLE: begin
          win_clr = 1'b1;
          if (scnt_q == S_LAST) begin
            scnt_d  = '0;
            state_d = locked_q ? ST_LOCKED : ST_MEASURE;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        ST_MEASURE: begin
          win_en = 1'b1;
          if (win_done) state_d = ST_DECIDE;
        end
        ST_DECIDE: begin
          win_clr = 1'b1;
          if (!locked_q) begin
            if (too_loud) g_try[k_q] = 1'b0;
            if (k_q != '0) begin
              g_try[k_q - KW'(1)] = 1'b1;
              k_d     = k_q - KW'(1);
              state_d = ST_SETTLE;
            end else begin
              busy_d   = 1'b0;
              locked_d = 1'b1;
              state_d  = ST_LOCKED;
            end
            gain_d = g_try;
          end
`ifdef AGC_TRACK_EN
          else if (too_loud && gain_q != '0) begin
            gain_d  = gain_q - GAIN_W'(1);
            state_d = ST_SETTLE;
          end else if (!too_loud && (win_peak < LO_T) && gain_q != GMAX) begin
            gain_d  = gain_q + GAIN_W'(1);
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_LOCKED;
          end
`endif
        end
        ST_LOCKED: begin
`ifdef AGC_TRACK_EN
          win_en = 1'b1;
          if (win_done) state_d = ST_DECIDE;
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      gain_q   <= MID;
      k_q      <= KW'(GAIN_W - 1);
      scnt_q   <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gain_q   <= gain_d;
      k_q      <= k_d;
      scnt_q   <= scnt_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
    end
  end

  assign gain   = gain_q;
  assign busy   = busy_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_agc_sar_tracker.sv
// Directed + randomized bench for agc_sar_tracker with a behavioural channel and search model.
module tb_agc_sar_tracker;

  localparam int SIG_W      = 16;
  localparam int GAIN_W     = 6;
  localparam int DWELL      = 4;
  localparam int SETTLE_CYC = 2;
  localparam int STEP       = SETTLE_CYC + DWELL + 1;
  localparam int LOCK_T     = GAIN_W * STEP;

  logic              clk = 1'b0;
  logic              RESET, start, freeze, sample_valid, overload;
  logic [SIG_W-1:0]  sample;
  logic [GAIN_W-1:0] gain;
  logic              busy, locked;

  int errors = 0;
  int checks = 0;
  // channel: 0 = overload when gain >= par (sample = s0); 1 = |sample| = gain*par clipped; 2 = -32768 always
  int ch_mode, ch_par, ch_s0;
  int trials[GAIN_W];
  int exp_final;

  always #5 clk = ~clk;

  agc_sar_tracker #(
    .SIG_W      (SIG_W),
    .GAIN_W     (GAIN_W),
    .DWELL      (DWELL),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk          (clk),
    .RESET        (RESET),
    .start        (start),
    .freeze       (freeze),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overload     (overload),
    .gain         (gain),
    .busy         (busy),
    .locked       (locked)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic bit loud(input int g);
    case (ch_mode)
      0:       return g >= ch_par;
      1:       return g * ch_par >= 32767;
      2:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Binary search over the gain code: try each bit from MSB, keep it if the channel stays quiet.
  task automatic model();
    int g = 0;
    for (int k = GAIN_W - 1; k >= 0; k--) begin
      trials[GAIN_W-1-k] = g | (1 << k);
      if (!loud(g | (1 << k))) g = g | (1 << k);
    end
    exp_final = g;
  endtask

  task automatic drive_ch();
    int g = int'(gain);
    int m;
    case (ch_mode)
      0: begin
        overload = (g >= ch_par);
        sample   = SIG_W'(ch_s0);
      end
      1: begin
        overload = 1'b0;
        m = g * ch_par;
        if (m >= 32767) sample = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7fff;
        else            sample = ($urandom_range(0, 1) != 0) ? SIG_W'(-m) : SIG_W'(m);
      end
      default: begin
        overload = 1'b0;
        sample   = 16'h8000;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_ch();
  endtask

  task automatic run_search(input int frz_at, input int frz_len);
    model();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_gain", int'(gain), trials[0]);
    chk("start_busy", int'(busy), 1);
    chk("start_locked", int'(locked), 0);
    for (int c = 1; c <= LOCK_T + frz_len; c++) begin
      if (c == frz_at) freeze = 1'b1;
      if (c == frz_at + frz_len) freeze = 1'b0;
      tick();
      if (frz_len == 0 && c % STEP == 0 && c < LOCK_T) chk("trial_gain", int'(gain), trials[c / STEP]);
      if (c == LOCK_T + frz_len - 1) begin
        chk("prelock_locked", int'(locked), 0);
        chk("prelock_busy", int'(busy), 1);
      end
    end
    chk("lock_locked", int'(locked), 1);
    chk("lock_busy", int'(busy), 0);
    chk("lock_gain", int'(gain), exp_final);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; freeze = 1'b0; sample_valid = 1'b1;
    overload = 1'b0; sample = '0;
    ch_mode = 0; ch_par = 64; ch_s0 = 0;
    tick(); tick();
    RESET = 1'b0;
    chk("rst_gain", int'(gain), 32);
    chk("rst_busy", int'(busy), 0);
    chk("rst_locked", int'(locked), 0);
    repeat (5) tick();
    chk("idle_gain", int'(gain), 32);
    chk("idle_busy", int'(busy), 0);

    // overload at gain >= 40 -> 39, trials 32,48,40,36,38,39
    ch_mode = 0; ch_par = 40; ch_s0 = 0;
    run_search(0, 0);
    chk("t40_final", int'(gain), 39);

`ifndef AGC_TRACK_EN
    // lock is terminal: even a channel that is now always loud leaves gain alone
    ch_par = 0;
    repeat (20) tick();
    chk("hold_gain", int'(gain), 39);
    chk("hold_locked", int'(locked), 1);
`endif

    ch_mode = 0; ch_par = 64; ch_s0 = 0;
    run_search(0, 0);
    chk("quiet_final", int'(gain), 63);
    ch_mode = 0; ch_par = 0;
    run_search(0, 0);
    chk("ovl_final", int'(gain), 0);
    ch_mode = 2;
    run_search(0, 0);
    chk("neg_full_final", int'(gain), 0);

    // freeze for 10 cycles during the first MEASURE window
    ch_mode = 0; ch_par = 40; ch_s0 = 0;
    run_search(4, 10);

    // RESET mid-MEASURE of the second step (gain is 48 there)
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    chk("mid_gain_pre", int'(gain), 48);
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("midrst_gain", int'(gain), 32);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_locked", int'(locked), 0);
    repeat (5) tick();
    chk("midrst_idle_busy", int'(busy), 0);

    // RESET and start together: reset wins
    RESET = 1'b1; start = 1'b1; tick(); RESET = 1'b0; start = 1'b0;
    tick();
    chk("rst_start_busy", int'(busy), 0);
    chk("rst_start_gain", int'(gain), 32);

    // restart mid-search
    start = 1'b1; tick(); start = 1'b0;
    repeat (17) tick();
    run_search(0, 0);

    for (int r = 0; r < 6; r++) begin
      ch_mode = int'($urandom_range(0, 1));
      ch_par  = (ch_mode == 0) ? int'($urandom_range(0, 64)) : int'($urandom_range(400, 40000));
      ch_s0   = int'($urandom_range(0, 30000));
      run_search(0, 0);
    end

`ifdef AGC_TRACK_EN
    ch_mode = 0; ch_par = 40; ch_s0 = 100;
    run_search(0, 0);
    repeat (4) tick();
    chk("trk_hold39", int'(gain), 39);
    tick();
    chk("trk_up40", int'(gain), 40);
    repeat (STEP) tick();
    chk("trk_back39", int'(gain), 39);
    chk("trk_locked", int'(locked), 1);
    chk("trk_busy", int'(busy), 0);
    ch_par = 64; ch_s0 = 100;
    run_search(0, 0);
    repeat (20) tick();
    chk("trk_sat63", int'(gain), 63);
    ch_par = 0;
    run_search(0, 0);
    repeat (20) tick();
    chk("trk_sat0", int'(gain), 0);
    chk("trk_sat0_locked", int'(locked), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/agc_sar_tracker.md
# agc_sar_tracker

Parametrised successor to the current AGC loop: a successive-approximation gain search over a GAIN_W-bit gain code, driven by both the ADC overload flag and a measured peak magnitude of the amplified signal. After lock, an optional tracking mode keeps nudging the gain. Sits between the ADC output and the existing gain-code-to-VGA mapping logic; it emits a raw gain code only.

## Interface
- SIG_W, 16, width of signed ADC sample
- GAIN_W, 6, gain code width (search steps = GAIN_W)
- DWELL, 16, valid samples observed per decision window (≥1)
- SETTLE_CYC, 4, cycles ignored after every gain change (≥1)
- HIGH_THRESH, 2**(SIG_W-1)-1, peak ≥ this → "too loud"
- LOW_THRESH, 2**(SIG_W-3), peak < this → "too quiet" (tracking only)
- clk  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins (or restarts) acquisition
- freeze  in  1  holds gain and pauses all counters while high
- sample  in  SIG_W  signed amplified ADC sample
- sample_valid  in  1  qualifies sample and overload
- overload  in  1  ADC saturation flag, sampled with sample_valid
- gain  out  GAIN_W  current gain code
- busy  out  1  search in progress
- locked  out  1  search complete, gain final (or tracking)

## Operation
- Reset: gain = 1<<(GAIN_W-1) (midpoint), busy=0, locked=0, state IDLE, window cleared.
- States: IDLE, SETTLE, MEASURE, DECIDE, LOCKED.
- IDLE: gain holds; start → gain = 1<<(GAIN_W-1), bit index k=GAIN_W-1, busy=1, locked=0, → SETTLE.
- SETTLE: counts SETTLE_CYC cycles regardless of sample_valid; window cleared; → MEASURE.
- MEASURE: per valid sample: mag = |sample|, with −2^(SIG_W-1) saturated to 2^(SIG_W-1)−1; peak = max(peak, mag); ovf |= overload. After DWELL valid samples → DECIDE.
- too_loud = ovf OR peak ≥ HIGH_THRESH.
- DECIDE (search): if too_loud, clear bit k. If k>0: set bit k−1, k−=1, → SETTLE. If k=0: busy=0, locked=1, → LOCKED.
- Result: largest gain code not too_loud, assuming a monotone channel; all too_loud → 0; never too_loud → 2^GAIN_W−1.
- LOCKED: behaviour per Configuration.
- freeze high: state, counters, window and gain all hold; invalid samples also ignored.
- start in any state (including mid-search or LOCKED) restarts the search from midpoint. RESET and start together: RESET wins.

## Timing
- Gain changes only on the DECIDE exit edge, or on the start edge (to midpoint).
- With sample_valid constantly high and freeze low: one step = SETTLE_CYC + DWELL + 1 cycles. locked rises GAIN_W*(SETTLE_CYC+DWELL+1) cycles after the edge that sampled start.
- busy and locked change on the same edge; they are never both 1.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- AGC_TRACK_EN defined: LOCKED repeats window measurement.
  - too_loud → gain−1, saturating at 0.
  - else peak < LOW_THRESH → gain+1, saturating at 2^GAIN_W−1.
  - Any change → SETTLE, then back to LOCKED measurement. locked stays 1.
- AGC_TRACK_EN undefined: LOCKED is terminal until start or RESET. Gain is frozen and LOW_THRESH is unused.

## Structure
- Package agc_pkg: state enum, abs-saturate function, default-threshold constants.
- Sub-module agc_window_detector: peak/overload accumulation over DWELL valid samples, with clear, freeze and a done pulse.
- The FSM and gain register live in the top module.

## Test plan
Common settings: GAIN_W=6, DWELL=4, SETTLE_CYC=2, valid always high.
- Overload asserted whenever gain ≥ 40, samples 0 → locked with gain=39, exactly 42 cycles after start.
- Samples 0, no overload → gain=63; overload always → gain=0; trial sequence 32,48,40,36,38,39 checked for the 39 case.
- Single sample −32768 per window with HIGH_THRESH=32767 → counts too_loud; final gain=0.
- AGC_TRACK_EN, locked at 39, then peak 100 < LOW_THRESH → gain 40 after 4+1 cycles. At 63, quiet windows keep it 63. At 0, overload keeps it 0.
- freeze held 10 cycles mid-MEASURE → lock time extends by exactly 10 cycles; same final gain.
- RESET mid-MEASURE → next cycle gain=32, busy=0, locked=0. start mid-search → restarts at 32 and completes in 42 cycles.
